// File: rtl/alu_issue_queue.sv
// alu_issue_queue: out-of-order issue queue feeding the ALU execute stage.
// Holds up to DEPTH renamed uops, wakes source operands from the two ALU
// bypass buses and selects one ready uop per cycle.
// Optional feature macro: ALU_IQ_AGE_SELECT_EN. When it is defined, an age
// matrix makes select pick the oldest ready entry. Otherwise select picks
// the lowest-index ready entry.

package alu_iq_pkg;

    localparam int PRF_W = 6;

    // Renamed ALU micro-op. pdst, alu_op and rob_idx are payload that the
    // queue carries through unchanged.
    typedef struct packed {
        logic             valid;
        logic             op0re;
        logic             op1re;
        logic [PRF_W-1:0] op0PAddr;
        logic [PRF_W-1:0] op1PAddr;
        logic [PRF_W-1:0] pdst;
        logic [3:0]       alu_op;
        logic [6:0]       rob_idx;
    } UOPBundle;

    // Writeback broadcast from one ALU pipe.
    typedef struct packed {
        logic             wen;
        logic [PRF_W-1:0] wrNum;
    } BypassInfo;

endpackage

module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PRF_W = alu_iq_pkg::PRF_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  UOPBundle                   enq_uop,
    input  logic                       enq_rdy0,
    input  logic                       enq_rdy1,
    output logic                       enq_ready,
    input  BypassInfo                  bypass_alu0,
    input  BypassInfo                  bypass_alu1,
    output logic                       iss_valid,
    output UOPBundle                   iss_uop,
    input  logic                       iss_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] r0;
    logic [DEPTH-1:0] r1;
    UOPBundle         uop_q [DEPTH];

    logic [DEPTH-1:0] cand;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] occ;
    logic             enq_fire;
    logic             alloc;
    logic             issue_fire;
    logic             alloc_r0;
    logic             alloc_r1;

    // True when either bypass bus is broadcasting the given tag this cycle.
    // Tag 0 is an ordinary tag.
    function automatic logic tag_hit(input logic [PRF_W-1:0] tag,
                                     input BypassInfo b0,
                                     input BypassInfo b1);
        return (b0.wen && (b0.wrNum == tag)) || (b1.wen && (b1.wrNum == tag));
    endfunction

    // An entry is a candidate when it is valid and both operands are ready.
    // An operand counts as ready when it is unused or its r bit is set.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = vld[i]
                   && (!uop_q[i].op0re || r0[i])
                   && (!uop_q[i].op1re || r1[i]);
        end
    end

    // Occupancy count and lowest-index free slot.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latches are inferred.
    always_comb begin
        occ      = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) free_idx = IDX_W'(i);
            occ = occ + CNT_W'(vld[i]);
        end
    end

`ifdef ALU_IQ_AGE_SELECT_EN
    // older_than[i][j] is set when entry j was allocated before entry i.
    logic [DEPTH-1:0] older_than [DEPTH];
    logic [DEPTH-1:0] oldest;

    // Oldest ready entry: a candidate that no older entry is also a candidate for.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            oldest[i] = cand[i] && !(|(cand & older_than[i]));
            if (oldest[i]) sel_idx = IDX_W'(i);
        end
    end

    // Age matrix update. A new entry is younger than every valid entry.
    // Its column is cleared so that stale bits left by a previous occupant
    // cannot survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) older_than[i] <= '0;
        end else if (alloc) begin
            for (int i = 0; i < DEPTH; i++) older_than[i][free_idx] <= 1'b0;
            older_than[free_idx] <= vld;
        end
    end
`else
    // Lowest-index ready entry.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) sel_idx = IDX_W'(i);
        end
    end
`endif

    assign iss_valid  = |cand;
    assign iss_uop    = uop_q[sel_idx];
    assign count      = occ;
    assign enq_ready  = (occ < CNT_W'(DEPTH));
    assign enq_fire   = enq_valid && enq_ready && !flush;
    assign alloc      = enq_fire && enq_uop.valid;
    assign issue_fire = iss_valid && iss_ready;
    assign alloc_r0   = enq_rdy0 || !enq_uop.op0re
                     || tag_hit(enq_uop.op0PAddr, bypass_alu0, bypass_alu1);
    assign alloc_r1   = enq_rdy1 || !enq_uop.op1re
                     || tag_hit(enq_uop.op1PAddr, bypass_alu0, bypass_alu1);

    // Entry control: flush/reset, operand wakeup, issue free, allocate.
    // NOTE: r0/r1 are not reset. They are only read while vld is set, and
    // allocation always writes them, so only vld needs a reset value.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && tag_hit(uop_q[i].op0PAddr, bypass_alu0, bypass_alu1))
                    r0[i] <= 1'b1;
                if (vld[i] && tag_hit(uop_q[i].op1PAddr, bypass_alu0, bypass_alu1))
                    r1[i] <= 1'b1;
            end
            if (issue_fire) vld[sel_idx] <= 1'b0;
            if (alloc) begin
                vld[free_idx] <= 1'b1;
                r0[free_idx]  <= alloc_r0;
                r1[free_idx]  <= alloc_r1;
            end
        end
    end

    // Payload storage. It has no reset because contents of invalid slots
    // are never observed.
    always_ff @(posedge clk) begin
        if (alloc) uop_q[free_idx] <= enq_uop;
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: a table of per-cycle vectors
// plus hand-written reset sequences.
// Expected issue order follows ALU_IQ_AGE_SELECT_EN when that macro is defined.

module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       enq_valid;
    UOPBundle   enq_uop;
    logic       enq_rdy0;
    logic       enq_rdy1;
    logic       enq_ready;
    BypassInfo  bypass_alu0;
    BypassInfo  bypass_alu1;
    logic       iss_valid;
    UOPBundle   iss_uop;
    logic       iss_ready;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    alu_issue_queue #(.DEPTH(8), .PRF_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_uop(enq_uop),
        .enq_rdy0(enq_rdy0), .enq_rdy1(enq_rdy1), .enq_ready(enq_ready),
        .bypass_alu0(bypass_alu0), .bypass_alu1(bypass_alu1),
        .iss_valid(iss_valid), .iss_uop(iss_uop), .iss_ready(iss_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus, followed by the outputs expected after the edge.
    typedef struct {
        logic       ev;
        logic       v;
        logic [6:0] id;
        logic       re0;
        logic [5:0] t0;
        logic       rd0;
        logic       re1;
        logic [5:0] t1;
        logic       rd1;
        logic       b0w;
        logic [5:0] b0n;
        logic       b1w;
        logic [5:0] b1n;
        logic       ir;
        logic       fl;
        logic       e_iv;
        logic [6:0] e_id;
        logic [3:0] e_cnt;
        logic       e_er;
    } vec_t;

    vec_t tbl[$];

`ifdef ALU_IQ_AGE_SELECT_EN
    localparam logic [6:0] FIRST_ID  = 7'd23;
    localparam logic [6:0] SECOND_ID = 7'd24;
`else
    localparam logic [6:0] FIRST_ID  = 7'd24;
    localparam logic [6:0] SECOND_ID = 7'd23;
`endif

    function automatic vec_t mk(input logic ev, input logic [6:0] id,
                                input logic re0, input logic [5:0] t0, input logic rd0,
                                input logic b0w, input logic [5:0] b0n,
                                input logic b1w, input logic [5:0] b1n,
                                input logic ir, input logic fl,
                                input logic e_iv, input logic [6:0] e_id,
                                input logic [3:0] e_cnt, input logic e_er);
        vec_t v;
        v.ev = ev;   v.v = 1'b1; v.id = id;
        v.re0 = re0; v.t0 = t0;  v.rd0 = rd0;
        v.re1 = 1'b0; v.t1 = 6'd0; v.rd1 = 1'b0;
        v.b0w = b0w; v.b0n = b0n; v.b1w = b1w; v.b1n = b1n;
        v.ir = ir;   v.fl = fl;
        v.e_iv = e_iv; v.e_id = e_id; v.e_cnt = e_cnt; v.e_er = e_er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        enq_valid   = 1'b0;
        enq_uop     = '0;
        enq_rdy0    = 1'b0;
        enq_rdy1    = 1'b0;
        bypass_alu0 = '0;
        bypass_alu1 = '0;
        iss_ready   = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        enq_valid            = v.ev;
        enq_uop              = '0;
        enq_uop.valid        = v.v;
        enq_uop.op0re        = v.re0;
        enq_uop.op1re        = v.re1;
        enq_uop.op0PAddr     = v.t0;
        enq_uop.op1PAddr     = v.t1;
        enq_uop.pdst         = v.id[5:0];
        enq_uop.alu_op       = 4'h3;
        enq_uop.rob_idx      = v.id;
        enq_rdy0             = v.rd0;
        enq_rdy1             = v.rd1;
        bypass_alu0.wen      = v.b0w;
        bypass_alu0.wrNum    = v.b0n;
        bypass_alu1.wen      = v.b1w;
        bypass_alu1.wrNum    = v.b1n;
        iss_ready            = v.ir;
        flush                = v.fl;
    endtask

    task automatic check_state(input string tag, input logic e_iv, input logic [6:0] e_id,
                               input logic [3:0] e_cnt, input logic e_er);
        check({tag, " iss_valid"}, 32'(iss_valid), 32'(e_iv));
        check({tag, " count"},     32'(count),     32'(e_cnt));
        check({tag, " enq_ready"}, 32'(enq_ready), 32'(e_er));
        if (e_iv) check({tag, " iss_uop.rob_idx"}, 32'(iss_uop.rob_idx), 32'(e_id));
    endtask

    initial begin
        vec_t v;

        // ev  id   re0 t0  rd0 b0w b0n b1w b1n ir fl | iv id cnt er
        // Uop A: both sources ready, issues one cycle after enqueue.
        tbl.push_back(mk(1, 7'd1, 1, 6'd5,  1, 0, 6'd0,  0, 6'd0,  0, 0, 1, 7'd1, 4'd1, 1));
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0, 4'd0, 1));
        // Uop B: src0 tag 12 waits for bypass_alu1 two cycles later.
        tbl.push_back(mk(1, 7'd2, 1, 6'd12, 0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0, 4'd1, 1));
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0, 4'd1, 1));
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 0, 6'd0,  1, 6'd12, 1, 0, 1, 7'd2, 4'd1, 1));
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0, 4'd0, 1));
        // Uop C: tag 7 is woken in the enqueue cycle; src1 comes from the busy table.
        v = mk(1, 7'd3, 1, 6'd7, 0, 1, 6'd7, 0, 6'd0, 0, 0, 1, 7'd3, 4'd1, 1);
        v.re1 = 1'b1; v.t1 = 6'd20; v.rd1 = 1'b1;
        tbl.push_back(v);
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0, 4'd0, 1));
        // Tag 0 is ordinary: ignored while wen=0, woken when wen=1.
        tbl.push_back(mk(1, 7'd4, 1, 6'd0,  0, 0, 6'd0,  0, 6'd0,  0, 0, 0, 7'd0, 4'd1, 1));
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 1, 6'd0,  0, 6'd0,  0, 0, 1, 7'd4, 4'd1, 1));
        tbl.push_back(mk(0, 7'd0, 0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0, 4'd0, 1));
        // A uop with valid=0 completes the handshake but allocates nothing.
        v = mk(1, 7'd5, 0, 6'd0, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 7'd0, 4'd0, 1);
        v.v = 1'b0;
        tbl.push_back(v);
        // Fill all 8 slots (ids 10..17) with nothing ready. Slot 1 waits on src1 tag 31.
        for (int k = 0; k < 8; k++) begin
            v = mk(1, 7'(10 + k), 1, 6'(30 + k), 0, 0, 6'd0, 0, 6'd0, 0, 0,
                   0, 7'd0, 4'(k + 1), (k < 7) ? 1'b1 : 1'b0);
            if (k == 1) begin
                v.re0 = 1'b0; v.re1 = 1'b1; v.t1 = 6'd31; v.rd1 = 1'b0;
            end
            tbl.push_back(v);
        end
        // The queue is full. Id 18 is held while slot 1 wakes through src1.
        tbl.push_back(mk(1, 7'd18, 0, 6'd0, 1, 0, 6'd0,  1, 6'd31, 0, 0, 1, 7'd11, 4'd8, 0));
        // An issue in a full cycle does not make room for a same-cycle enqueue.
        tbl.push_back(mk(1, 7'd18, 0, 6'd0, 1, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0,  4'd7, 1));
        tbl.push_back(mk(1, 7'd18, 0, 6'd0, 1, 0, 6'd0,  0, 6'd0,  0, 0, 1, 7'd18, 4'd8, 0));
        tbl.push_back(mk(0, 7'd0,  0, 6'd0, 0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0,  4'd7, 1));
        // Flush with enqueue, wakeup and issue_ready all active: everything is dropped.
        tbl.push_back(mk(1, 7'd19, 0, 6'd0, 1, 1, 6'd30, 0, 6'd0,  1, 1, 0, 7'd0,  4'd0, 1));
        tbl.push_back(mk(0, 7'd0,  0, 6'd0, 0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0,  4'd0, 1));
        // Age ordering: D lands in slot 3, slot 0 is freed, E takes slot 0, then both wake.
        tbl.push_back(mk(1, 7'd20, 1, 6'd40, 0, 0, 6'd0,  0, 6'd0,  0, 0, 0, 7'd0,  4'd1, 1));
        tbl.push_back(mk(1, 7'd21, 1, 6'd41, 0, 0, 6'd0,  0, 6'd0,  0, 0, 0, 7'd0,  4'd2, 1));
        tbl.push_back(mk(1, 7'd22, 1, 6'd42, 0, 0, 6'd0,  0, 6'd0,  0, 0, 0, 7'd0,  4'd3, 1));
        tbl.push_back(mk(1, 7'd23, 1, 6'd43, 0, 1, 6'd40, 0, 6'd0,  0, 0, 1, 7'd20, 4'd4, 1));
        tbl.push_back(mk(0, 7'd0,  0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0,  4'd3, 1));
        tbl.push_back(mk(1, 7'd24, 1, 6'd44, 0, 0, 6'd0,  0, 6'd0,  0, 0, 0, 7'd0,  4'd4, 1));
        tbl.push_back(mk(0, 7'd0,  0, 6'd0,  0, 1, 6'd43, 1, 6'd44, 0, 0, 1, FIRST_ID,  4'd4, 1));
        tbl.push_back(mk(0, 7'd0,  0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 1, SECOND_ID, 4'd3, 1));
        tbl.push_back(mk(0, 7'd0,  0, 6'd0,  0, 0, 6'd0,  0, 6'd0,  1, 0, 0, 7'd0,      4'd2, 1));

        // Reset sequence.
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("reset", 1'b0, 7'd0, 4'd0, 1'b1);

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_state($sformatf("v%0d", i), tbl[i].e_iv, tbl[i].e_id, tbl[i].e_cnt, tbl[i].e_er);
        end

        // Mid-run reset: two entries are still resident. Reset empties the
        // queue, and a fresh uop enqueued afterwards issues normally.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("midrst", 1'b0, 7'd0, 4'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 7'd50, 1, 6'd9, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 7'd0, 4'd0, 0));
        @(posedge clk);
        #1;
        check_state("postrst", 1'b1, 7'd50, 4'd1, 1'b1);
        @(negedge clk);
        idle_inputs();
        iss_ready = 1'b1;
        @(posedge clk);
        #1;
        check_state("postrst_iss", 1'b0, 7'd0, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
